// File: rtl/tdm_demux4_4bits_pkg.sv
// tdm_demux4_4bits_pkg: shared constants and FSM state type for the TDM demultiplexer
package tdm_demux4_4bits_pkg;
   localparam int NSLOTS    = 4;
   localparam int SW        = $clog2(NSLOTS);
   localparam int DEF_WIDTH = 4;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/tdm_demux4_4bits_if.sv
// tdm_demux4_4bits_if: TDM demux bus
//   inputs : in_data, in_valid, frame_sync
//   outputs: out0..out3, out_valid (one-hot), slot, frame_done, sync_err, locked
interface tdm_demux4_4bits_if import tdm_demux4_4bits_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
   logic [WIDTH-1:0]  in_data;
   logic              in_valid;
   logic              frame_sync;
   logic [WIDTH-1:0]  out0, out1, out2, out3;
   logic [NSLOTS-1:0] out_valid;
   logic [SW-1:0]     slot;
   logic              frame_done;
   logic              sync_err;
   logic              locked;
   modport master (output in_data, in_valid, frame_sync,
                   input  out0, out1, out2, out3, out_valid, slot, frame_done, sync_err, locked);
   modport slave  (input  in_data, in_valid, frame_sync,
                   output out0, out1, out2, out3, out_valid, slot, frame_done, sync_err, locked);
endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index counter with restart and wrap detection
//   advance: a word is accepted this cycle; restart: frame_sync forces slot 0
//   slot   : slot the next accepted word goes to; wrap: slot 3 is being written now
module tdm_slot_counter import tdm_demux4_4bits_pkg::*; (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          advance,
   input  logic          restart,
   output logic [SW-1:0] slot,
   output logic          wrap
);
   logic [SW-1:0] slot_q, slot_d;
   // a restart with a same-cycle word lands that word in slot 0, so the counter resumes at 1
   always_comb begin
      slot_d = restart ? SW'(advance) : slot_q + SW'(advance);
      wrap   = advance & ~restart & (slot_q == SW'(NSLOTS - 1));
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) slot_q <= '0;
      else        slot_q <= slot_d;
   assign slot = slot_q;
endmodule

// File: rtl/tdm_demux4_4bits.sv
// tdm_demux4_4bits: 4-slot TDM demultiplexer with frame lock and sync error detection
//   clk, rst_n (async, active low); bus: slave side of tdm_demux4_4bits_if
module tdm_demux4_4bits import tdm_demux4_4bits_pkg::*; #(
   parameter int WIDTH         = DEF_WIDTH,
   parameter bit CLEAR_ON_SYNC = 1'b0
) (
   input logic               clk,
   input logic               rst_n,
   tdm_demux4_4bits_if.slave bus
);
   state_t            state_q, state_d;
   logic              run, advance, restart, wrap, se_d, fd_q, se_q;
   logic [SW-1:0]     slot, wslot;
   logic [NSLOTS-1:0] ov_q, ov_d;
   logic [WIDTH-1:0]  ch_q [NSLOTS];
   logic [WIDTH-1:0]  ch_d [NSLOTS];
   assign run     = state_q == RUN;
   assign restart = bus.frame_sync;
   // words are only accepted once locked, or on the very cycle that locks
   assign advance = bus.in_valid & (run | bus.frame_sync);
   tdm_slot_counter u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (advance),
      .restart (restart),
      .slot    (slot),
      .wrap    (wrap)
   );
   always_comb begin
      state_d = (run | bus.frame_sync) ? RUN : IDLE;
      wslot   = restart ? '0 : slot;
      ov_d    = advance ? NSLOTS'(1) << wslot : '0;
      se_d    = run & restart & (slot != '0);
      // the write wins over the sync clear for the addressed channel
      for (int i = 0; i < NSLOTS; i++)
         ch_d[i] = (advance && wslot == SW'(i)) ? bus.in_data :
                   (CLEAR_ON_SYNC && restart)  ? '0 : ch_q[i];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         ov_q    <= '0;
         fd_q    <= 1'b0;
         se_q    <= 1'b0;
         for (int i = 0; i < NSLOTS; i++) ch_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ov_q    <= ov_d;
         fd_q    <= wrap;
         se_q    <= se_d;
         for (int i = 0; i < NSLOTS; i++) ch_q[i] <= ch_d[i];
      end
   assign bus.out0       = ch_q[0];
   assign bus.out1       = ch_q[1];
   assign bus.out2       = ch_q[2];
   assign bus.out3       = ch_q[3];
   assign bus.out_valid  = ov_q;
   assign bus.slot       = slot;
   assign bus.frame_done = fd_q;
   assign bus.sync_err   = se_q;
   assign bus.locked     = run;
endmodule

// File: tb/tb_tdm_demux4_4bits.sv
// tb_tdm_demux4_4bits: directed and random stimulus against a frame-level reference model
module tb_tdm_demux4_4bits;
   import tdm_demux4_4bits_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   tdm_demux4_4bits_if #(.WIDTH(4)) if0 ();
   tdm_demux4_4bits_if #(.WIDTH(4)) if1 ();
   assign if1.in_data    = if0.in_data;
   assign if1.in_valid   = if0.in_valid;
   assign if1.frame_sync = if0.frame_sync;
   tdm_demux4_4bits #(.WIDTH(4), .CLEAR_ON_SYNC(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   tdm_demux4_4bits #(.WIDTH(4), .CLEAR_ON_SYNC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   int errs = 0;
   int checks = 0;
   // reference model: index 0 without clear-on-sync, index 1 with it
   bit         m_lock;
   int         m_slot;
   logic [3:0] m_ch [2][4];
   logic [3:0] m_ov;
   bit         m_fd, m_se;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_lock = 0; m_slot = 0; m_ov = 0; m_fd = 0; m_se = 0;
      for (int k = 0; k < 2; k++) for (int n = 0; n < 4; n++) m_ch[k][n] = 0;
   endtask
   task automatic model_step(input bit fs, input bit v, input logic [3:0] d);
      m_ov = 0; m_fd = 0; m_se = 0;
      if (fs) begin
         m_se   = m_lock && m_slot != 0;
         m_slot = 0;
         m_lock = 1;
         for (int n = 0; n < 4; n++) m_ch[1][n] = 0;
      end
      if (v && m_lock) begin
         m_ch[0][m_slot] = d;
         m_ch[1][m_slot] = d;
         m_ov   = 4'(1 << m_slot);
         m_fd   = m_slot == 3;
         m_slot = (m_slot + 1) % 4;
      end
   endtask
   task automatic compare(input string tag);
      chk({tag, ".outs0"}, {if0.out3, if0.out2, if0.out1, if0.out0}, {m_ch[0][3], m_ch[0][2], m_ch[0][1], m_ch[0][0]});
      chk({tag, ".outs1"}, {if1.out3, if1.out2, if1.out1, if1.out0}, {m_ch[1][3], m_ch[1][2], m_ch[1][1], m_ch[1][0]});
      chk({tag, ".ctl0"}, {if0.out_valid, if0.slot, if0.frame_done, if0.sync_err, if0.locked},
          {m_ov, 2'(m_slot), m_fd, m_se, m_lock});
      chk({tag, ".ctl1"}, {if1.out_valid, if1.slot, if1.frame_done, if1.sync_err, if1.locked},
          {m_ov, 2'(m_slot), m_fd, m_se, m_lock});
      chk({tag, ".onehot"}, 32'($countones(if0.out_valid) <= 1), 32'd1);
      chk({tag, ".fd_se_excl"}, 32'(if0.frame_done & if0.sync_err), 32'd0);
   endtask
   task automatic cyc(input bit fs, input bit v, input logic [3:0] d, input string tag);
      if0.frame_sync = fs;
      if0.in_valid   = v;
      if0.in_data    = d;
      @(posedge clk);
      model_step(fs, v, d);
      @(negedge clk);
      compare(tag);
   endtask
   initial begin
      if0.frame_sync = 0; if0.in_valid = 0; if0.in_data = 0;
      model_reset();
      repeat (2) @(negedge clk);
      compare("reset");
      rst_n = 1'b1;
      repeat (3) cyc(0, 1, 4'h3, "unlocked");
      cyc(1, 1, 4'hA, "frameA");
      cyc(0, 1, 4'hB, "frameB");
      cyc(0, 1, 4'hC, "frameC");
      cyc(0, 1, 4'hD, "frameD");
      cyc(0, 0, 4'h0, "hold");
      cyc(0, 1, 4'h1, "part1");
      cyc(0, 1, 4'h2, "part2");
      cyc(1, 1, 4'h7, "resync");
      cyc(0, 0, 4'h0, "after_resync");
      cyc(1, 0, 4'h0, "sync_only");
      for (int w = 0; w < 4; w++) begin
         cyc(0, 1, 4'(w + 4), "gap_word");
         repeat (3) cyc(0, 0, 4'h0, "gap_idle");
      end
      cyc(0, 1, 4'hF, "clrF");
      cyc(0, 1, 4'hE, "clrE");
      cyc(0, 1, 4'hD, "clrD");
      cyc(0, 1, 4'hC, "clrC");
      cyc(1, 0, 4'h0, "clr_sync");
      cyc(0, 1, 4'hF, "clrF2");
      cyc(0, 1, 4'hE, "clrE2");
      cyc(0, 1, 4'hD, "clrD2");
      cyc(0, 1, 4'hC, "clrC2");
      cyc(1, 1, 4'h5, "clr_sync_wr");
      cyc(0, 1, 4'h6, "pre_rst1");
      cyc(0, 1, 4'h8, "pre_rst2");
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cyc(0, 1, 4'h9, "post_rst_ignored");
      cyc(1, 0, 4'h0, "post_rst_sync");
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(7) == 0, 1'($urandom_range(1)), 4'($urandom), "rand");
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/tdm_demux4_4bits.md
TDM_DEMUX4_4BITS -- requirements
Module: tdm_demux4_4bits

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each data word.
REQ-002 Parameter CLEAR_ON_SYNC, default 0: when 1, every frame_sync clears out0..out3 to zero.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 in_data  input  WIDTH: time-multiplexed data word.
REQ-007 in_valid  input  1: in_data is valid this cycle.
REQ-008 frame_sync  input  1: single-cycle pulse marking slot 0 of a frame.
REQ-009 out0, out1, out2, out3  output  WIDTH each: registered per-channel data, held between updates.
REQ-010 out_valid  output  4: one-hot pulse; bit n is high for one cycle when outn has just been updated.
REQ-011 slot  output  2: slot index that the next accepted word will be written to.
REQ-012 frame_done  output  1: one-cycle pulse after the slot-3 word is written.
REQ-013 sync_err  output  1: one-cycle pulse when frame_sync arrives while slot != 0 in RUN.
REQ-014 locked  output  1: high while the FSM is in RUN.

Function
REQ-015 The FSM SHALL have two states, IDLE and RUN.
REQ-016 IDLE: in_valid is ignored and no output changes, except as REQ-017 allows.
REQ-017 IDLE + frame_sync -> RUN, with slot = 0.
REQ-018 IDLE + frame_sync + in_valid in the same cycle: the word SHALL go to out0, and slot becomes 1.
REQ-019 RUN + in_valid: in_data SHALL be written to out[slot], out_valid[slot] pulses on the next cycle (latency 1), and slot increments.
REQ-020 Writing slot 3 SHALL wrap slot to 0 and pulse frame_done in the same cycle as out_valid[3].
REQ-021 The FSM SHALL stay in RUN after wrap-around.
REQ-022 RUN, frame_sync with slot = 0: normal frame start, with no sync_err.
REQ-023 RUN, frame_sync with slot != 0: sync_err pulses next cycle, slot forces to 0, and no frame_done is issued for the partial frame.
REQ-024 RUN, frame_sync + in_valid in the same cycle: the word SHALL be written to slot 0 regardless of the previous slot, and slot becomes 1.
REQ-025 in_valid low SHALL NOT advance slot; gaps of any length are permitted.
REQ-026 CLEAR_ON_SYNC = 1: on frame_sync, out0..out3 clear to 0 on the next cycle. A same-cycle in_valid word SHALL still be written to out0, since the write takes priority over the clear.
REQ-027 out_valid SHALL have at most one bit set in any cycle.
REQ-028 frame_done and sync_err SHALL never both be high in the same cycle.
REQ-029 Channel registers not addressed SHALL hold their value.

Reset
REQ-030 rst_n low SHALL asynchronously force the state to IDLE and slot to 0.
REQ-031 rst_n low SHALL asynchronously force out0..out3, out_valid, frame_done, sync_err and locked to 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release the block waits in IDLE for frame_sync.
REQ-033 The first rising edge after rst_n rises SHALL be a normal operating edge.

Structure
REQ-034 A shared package SHALL hold the IDLE/RUN state typedef, the slot-count constant (4) and the default WIDTH.
REQ-035 The slot counter with sync/wrap logic SHALL be a sub-module, tdm_slot_counter (ports: clk, rst_n, advance, restart, slot, wrap).
REQ-036 The data-path registers SHALL stay in the top module.

Verification
REQ-037 Reset, then in_valid pulses with 0x3 without frame_sync -> all outputs stay 0 and locked = 0.
REQ-038 frame_sync + in_valid 0xA, then 0xB, 0xC, 0xD on consecutive cycles -> out0..out3 = A, B, C, D; out_valid = 0001, 0010, 0100, 1000; frame_done together with the 1000 pulse.
REQ-039 After locking, send words 0x1 and 0x2, then frame_sync + 0x7 -> sync_err pulse, out0 = 7, slot = 1, no frame_done.
REQ-040 Send four words separated by 3-cycle in_valid gaps -> slot advances only on valid cycles; frame_done after the fourth word.
REQ-041 Assert rst_n low after slot 2 has been written -> all outputs 0 immediately (asynchronously); after release, words are ignored until frame_sync.
REQ-042 CLEAR_ON_SYNC = 1, full frame F,E,D,C, then frame_sync with no in_valid -> out0..out3 = 0 on the next cycle with no out_valid; repeat with in_valid 0x5 -> out0 = 5, others 0.
